mode_ctrl_param: RTL

Parametrised control-path FSM sequencing the s/y datapath through four regimes: off, timed countdown list, free count, and y update. It sits between the mode/start inputs and the datapath register enables, and generalises the fixed 6-4-2-0 countdown and wrap-at-3 counter to configurable values, dwell and width. It adds step-index and done outputs.

---
 rtl/mode_ctrl_pkg.sv | 32 +++
 rtl/mode_ctrl_param_dwell_timer.sv | 33 +++
 rtl/mode_ctrl_param.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mode_ctrl_pkg.sv
// Shared encodings for the mode control FSM: regimes, y ops, states.
// Optional abort path is enabled by defining MODE_CTRL_ABORT_EN.
package mode_ctrl_pkg;

    localparam logic [1:0] REG_OFF   = 2'd0;
    localparam logic [1:0] REG_LIST  = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_UPD   = 2'd3;

    localparam logic [1:0] YSEL_HOLD = 2'd0;
    localparam logic [1:0] YSEL_DEC  = 2'd1;
    localparam logic [1:0] YSEL_INC  = 2'd2;
    localparam logic [1:0] YSEL_CLR  = 2'd3;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LIST_WAIT = 3'd1;
    localparam logic [2:0] ST_LIST_RUN  = 3'd2;
    localparam logic [2:0] ST_COUNT     = 3'd3;
    localparam logic [2:0] ST_UPD_LOAD  = 3'd4;
    localparam logic [2:0] ST_UPD_SEL   = 3'd5;
    localparam logic [2:0] ST_UPD_CLR   = 3'd6;

    function automatic logic [1:0] regime_of(input logic [2:0] st);
        case (st)
            ST_LIST_WAIT, ST_LIST_RUN:           return REG_LIST;
            ST_COUNT:                            return REG_COUNT;
            ST_UPD_LOAD, ST_UPD_SEL, ST_UPD_CLR: return REG_UPD;
            default:                             return REG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/mode_ctrl_param_dwell_timer.sv
// Dwell timer: loads DWELL-1, counts down to zero and holds there.
// first marks the cycle right after a load; zero marks the last cycle.
module mode_ctrl_param_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic first,
    output logic zero
);
    import mode_ctrl_pkg::*;

    localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [TW-1:0] cnt;

    // Reload on request, otherwise count down and stick at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(DWELL - 1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero  = (cnt == '0);
    assign first = (cnt == TW'(DWELL - 1));

endmodule

// File: rtl/mode_ctrl_param.sv
// Control FSM sequencing the s/y datapath: off, countdown list, count, update.
// Define MODE_CTRL_ABORT_EN to let on=0 abort LIST_RUN/COUNT and clear s.
module mode_ctrl_param
    import mode_ctrl_pkg::*;
#(
    parameter int S_W        = 4,
    parameter int LIST_START = 6,
    parameter int LIST_DEC   = 2,
    parameter int LIST_LEN   = 4,
    parameter int DWELL      = 4,
    parameter int S_MAX      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  on,
    input  logic                        start,
    output logic [1:0]                  regime,
    output logic                        active,
    output logic [1:0]                  y_select_next,
    output logic [S_W-1:0]              s_step,
    output logic                        y_en,
    output logic                        s_en,
    output logic                        y_store_x,
    output logic                        s_add,
    output logic                        s_zero,
    output logic [$clog2(LIST_LEN)-1:0] step_idx,
    output logic                        done
);
    localparam int IW = $clog2(LIST_LEN);

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [IW-1:0]  idx;
    logic [S_W-1:0] mir;
    logic           t_load;
    logic           t_first;
    logic           t_zero;
    logic           abort;
    logic           last_step;
    logic           mir_wrap;
    logic           st_run;
    logic           st_count;

`ifdef MODE_CTRL_ABORT_EN
    assign abort = (on == 2'd0);
`else
    assign abort = 1'b0;
`endif

    assign st_run    = (state == ST_LIST_RUN);
    assign st_count  = (state == ST_COUNT);
    assign last_step = (idx == IW'(LIST_LEN - 1));
    assign mir_wrap  = (mir == S_W'(S_MAX));

    mode_ctrl_param_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (t_load),
        .en    (st_run),
        .first (t_first),
        .zero  (t_zero)
    );

    // Next-state selection and dwell-timer reload requests.
    always_comb begin
        state_nxt = state;
        t_load    = 1'b0;
        case (state)
            ST_IDLE: begin
                case (on)
                    2'd1:    state_nxt = ST_LIST_WAIT;
                    2'd2:    state_nxt = ST_COUNT;
                    2'd3:    state_nxt = ST_UPD_LOAD;
                    default: state_nxt = ST_IDLE;
                endcase
            end
            ST_LIST_WAIT: begin
                if (start) begin
                    state_nxt = ST_LIST_RUN;
                    t_load    = 1'b1;
                end else if (on == 2'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LIST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (t_zero) begin
                    if (last_step) state_nxt = ST_IDLE;
                    else           t_load    = 1'b1;
                end
            end
            ST_COUNT: begin
                if (abort || !start) state_nxt = ST_IDLE;
            end
            ST_UPD_LOAD: state_nxt = ST_UPD_SEL;
            ST_UPD_SEL:  state_nxt = ST_UPD_CLR;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // State, step index and COUNT mirror; idx/mir read zero outside their regime.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            mir   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != ST_LIST_RUN) begin
                idx <= '0;
            end else if (st_run && t_load) begin
                idx <= idx + 1'b1;
            end
            if (st_count && state_nxt == ST_COUNT) begin
                mir <= mir_wrap ? '0 : mir + 1'b1;
            end else begin
                mir <= '0;
            end
        end
    end

    // Output decode from state, timer and mirror (COUNT also gated by start).
    always_comb begin
        regime        = regime_of(state);
        active        = 1'b0;
        y_select_next = YSEL_HOLD;
        s_step        = '0;
        y_en          = 1'b0;
        s_en          = 1'b0;
        y_store_x     = 1'b0;
        s_add         = 1'b0;
        s_zero        = 1'b0;
        done          = 1'b0;
        unique case (1'b1)
            (st_run || st_count) && abort: begin
                s_en   = 1'b1;
                s_zero = 1'b1;
            end
            st_run && !abort: begin
                active = 1'b1;
                if (t_first) begin
                    s_en = 1'b1;
                    if (idx == '0) begin
                        s_zero = 1'b1;
                        s_add  = 1'b1;
                        s_step = S_W'(LIST_START);
                    end else begin
                        s_step = S_W'(LIST_DEC);
                    end
                end
                done = t_zero && last_step;
            end
            st_count && !abort && start: begin
                s_en  = 1'b1;
                s_add = 1'b1;
                if (mir_wrap) begin
                    s_zero        = 1'b1;
                    y_en          = 1'b1;
                    y_select_next = YSEL_INC;
                end else begin
                    s_step = S_W'(1);
                end
            end
            state == ST_UPD_LOAD: begin
                y_en      = 1'b1;
                y_store_x = 1'b1;
            end
            state == ST_UPD_SEL: begin
                y_en          = 1'b1;
                y_select_next = YSEL_INC;
            end
            state == ST_UPD_CLR: begin
                s_en   = 1'b1;
                s_zero = 1'b1;
                s_add  = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign step_idx = idx;

endmodule
